// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage
//
// Pipeline stage between execute and write-back.
//   * EX/MEM register: captures the execute results whenever stall is low.
//   * Data-memory port: request/grant/response handshake for loads and
//     stores, one access outstanding at a time (FSM IDLE -> REQ -> RESP).
//   * Load data is lane-selected by addr[1:0] and sign/zero extended.
//   * MEM/WB register: registered result presented to write-back.
//   * EX/MEM forwarding sources for the execute stage, plus an upstream stall
//     while a memory access has not yet completed.
//
// Optional feature (macro MEMORY_STAGE_MISALIGN_CHECK_EN):
//   misaligned halfword/word accesses issue no memory request, retire in one
//   cycle without writing the register file, and pulse misalign_err.
//
// Ports:
//   clk, rst (sync, active-low)
//   ex_*            execute results / control into the EX/MEM register
//   stall           upstream hold request
//   ex_mem_rd, ex_mem_RegWrite, forward_ex_mem   forwarding sources
//   dmem_*          data-memory request/grant/response port
//   wb_*            MEM/WB register outputs
//   misalign_err    (only with MEMORY_STAGE_MISALIGN_CHECK_EN)
// -----------------------------------------------------------------------------
module memory_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_data,
  input  logic [31:0] ex_memory_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_RegWrite,
  input  logic        ex_MemRead,
  input  logic        ex_MemWrite,
  input  logic        ex_MemToReg,
  input  logic [2:0]  ex_funct3,
  output logic        stall,
  output logic [4:0]  ex_mem_rd,
  output logic        ex_mem_RegWrite,
  output logic [31:0] forward_ex_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_RegWrite,
  output logic [31:0] wb_data
`ifdef MEMORY_STAGE_MISALIGN_CHECK_EN
  ,
  output logic        misalign_err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;

  // Byte enables: funct3[1:0] gives the access size.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] addr);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << addr;
      2'b01:   be = 4'b0011 << {addr[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated into every lane so the byte enables pick the target.
  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] w;
    case (size)
      2'b00:   w = {4{data[7:0]}};
      2'b01:   w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

  // Select the addressed lane of the load word, then sign/zero extend.
  function automatic logic [31:0] load_align(input logic [2:0]  f3,
                                             input logic [1:0]  addr,
                                             input logic [31:0] word);
    logic [31:0] shifted;
    logic [15:0] half;
    logic [31:0] r;
    shifted = word >> {addr, 3'b000};
    half    = addr[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  r = {{16{half[15]}}, half};
      3'b100:  r = {24'd0, shifted[7:0]};
      3'b101:  r = {16'd0, half};
      default: r = word;
    endcase
    return r;
  endfunction

  // EX/MEM register
  logic        exm_valid_q, exm_regwrite_q, exm_memread_q, exm_memwrite_q, exm_memtoreg_q;
  logic [4:0]  exm_rd_q;
  logic [31:0] exm_alu_q, exm_store_q;
  logic [2:0]  exm_funct3_q;

  state_e      state_q, state_d;
  logic        misalign, mem_op, acc_done;

  // MEM/WB register
  logic        wb_valid_q, wb_valid_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q, wb_data_d;

`ifdef MEMORY_STAGE_MISALIGN_CHECK_EN
  logic        misalign_err_q;
  assign misalign = exm_valid_q & (exm_memread_q | exm_memwrite_q) &
                    (((exm_funct3_q[1:0] == 2'b01) & exm_alu_q[0]) |
                     ((exm_funct3_q[1:0] == 2'b10) & (exm_alu_q[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign mem_op = exm_valid_q & (exm_memread_q | exm_memwrite_q) & ~misalign;

  // ---- EX/MEM stage boundary ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      exm_valid_q    <= 1'b0;
      exm_regwrite_q <= 1'b0;
      exm_memread_q  <= 1'b0;
      exm_memwrite_q <= 1'b0;
      exm_memtoreg_q <= 1'b0;
      exm_rd_q       <= 5'd0;
      exm_alu_q      <= 32'd0;
    end else if (!stall) begin
      exm_valid_q    <= ex_valid;
      exm_regwrite_q <= ex_RegWrite;
      exm_memread_q  <= ex_MemRead;
      exm_memwrite_q <= ex_MemWrite;
      exm_memtoreg_q <= ex_MemToReg;
      exm_rd_q       <= ex_rd;
      exm_alu_q      <= ex_alu_data;
    end
  end

  // Pure data fields: meaningless while exm_valid_q is low, so never reset.
  always_ff @(posedge clk) begin
    if (!stall) begin
      exm_store_q  <= ex_memory_data;
      exm_funct3_q <= ex_funct3;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state. A read takes priority if both MemRead and MemWrite are set.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          if (dmem_gnt) state_d = exm_memread_q ? S_RESP : S_IDLE;
          else          state_d = S_REQ;
        end
      end
      S_REQ:   if (dmem_gnt)    state_d = exm_memread_q ? S_RESP : S_IDLE;
      S_RESP:  if (dmem_rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs. The request is combinational in IDLE so a same-cycle grant
  // lets a store retire without stalling.
  always_comb begin
    dmem_req = mem_op & (state_q != S_RESP);
    acc_done = (dmem_req & dmem_gnt & ~exm_memread_q) |
               ((state_q == S_RESP) & dmem_rvalid);
    stall    = mem_op & ~acc_done;
  end

  // Address/data/enables come straight from the held EX/MEM entry, so they
  // stay stable for the whole request phase.
  assign dmem_we    = exm_memwrite_q & ~exm_memread_q;
  assign dmem_addr  = {exm_alu_q[31:2], 2'b00};
  assign dmem_wdata = lane_wdata(exm_funct3_q[1:0], exm_store_q);
  assign dmem_be    = lane_be(exm_funct3_q[1:0], exm_alu_q[1:0]);

  assign ex_mem_rd       = exm_rd_q;
  assign ex_mem_RegWrite = exm_regwrite_q & exm_valid_q;
  assign forward_ex_mem  = exm_alu_q;

  // Retire when the entry is not waiting on memory; stalled cycles are bubbles.
  always_comb begin
    wb_valid_d    = exm_valid_q & ~stall;
    wb_regwrite_d = wb_valid_d & exm_regwrite_q & ~dmem_we & ~misalign;
    wb_data_d     = (mem_op & exm_memread_q & exm_memtoreg_q)
                    ? load_align(exm_funct3_q, exm_alu_q[1:0], dmem_rdata)
                    : exm_alu_q;
  end

  // ---- MEM/WB stage boundary ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_rd_q       <= 5'd0;
      wb_data_q     <= 32'd0;
    end else begin
      wb_valid_q    <= wb_valid_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_rd_q       <= exm_rd_q;
      wb_data_q     <= wb_data_d;
    end
  end

  assign wb_valid    = wb_valid_q;
  assign wb_RegWrite = wb_regwrite_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;

`ifdef MEMORY_STAGE_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst) misalign_err_q <= 1'b0;
    else      misalign_err_q <= misalign;
  end
  assign misalign_err = misalign_err_q;
`endif

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_alu_data;
  logic [31:0] ex_memory_data;
  logic [4:0]  ex_rd;
  logic        ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg;
  logic [2:0]  ex_funct3;
  logic        stall;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_RegWrite;
  logic [31:0] forward_ex_mem;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_RegWrite;
  logic [31:0] wb_data;
`ifdef MEMORY_STAGE_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  memory_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_alu_data(ex_alu_data), .ex_memory_data(ex_memory_data),
    .ex_rd(ex_rd), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_MemToReg(ex_MemToReg), .ex_funct3(ex_funct3),
    .stall(stall), .ex_mem_rd(ex_mem_rd), .ex_mem_RegWrite(ex_mem_RegWrite),
    .forward_ex_mem(forward_ex_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_RegWrite(wb_RegWrite), .wb_data(wb_data)
`ifdef MEMORY_STAGE_MISALIGN_CHECK_EN
    , .misalign_err(misalign_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [31:0] alu, input logic [31:0] md,
                        input logic [4:0] rd, input logic rw, input logic mr,
                        input logic mw, input logic m2r, input logic [2:0] f3);
    ex_valid = v; ex_alu_data = alu; ex_memory_data = md; ex_rd = rd;
    ex_RegWrite = rw; ex_MemRead = mr; ex_MemWrite = mw; ex_MemToReg = m2r;
    ex_funct3 = f3;
  endtask

  task automatic set_idle();
    set_ex(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
  endtask

  // Load with gw cycles before grant and rw RESP cycles before rvalid.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] rdata, input int gw, input int rw,
                         input logic [31:0] exp);
    set_ex(1'b1, addr, 32'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, f3);
    step();
    set_idle();
    for (int i = 0; i < gw; i++) begin
      dmem_gnt = 1'b0;
      #1;
      chk({tag, "_req_wait"}, dmem_req, 1);
      chk({tag, "_stall_wait"}, stall, 1);
      step();
    end
    dmem_gnt = 1'b1;
    #1;
    chk({tag, "_req"}, dmem_req, 1);
    chk({tag, "_we"}, dmem_we, 0);
    chk({tag, "_addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
    chk({tag, "_stall_gnt"}, stall, 1);
    step();
    dmem_gnt = 1'b0;
    for (int i = 0; i < rw; i++) begin
      #1;
      chk({tag, "_stall_resp"}, stall, 1);
      chk({tag, "_req_resp"}, dmem_req, 0);
      chk({tag, "_bubble"}, wb_valid, 0);
      step();
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    #1;
    chk({tag, "_stall_done"}, stall, 0);
    step();
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'd0;
    chk({tag, "_wb_valid"}, wb_valid, 1);
    chk({tag, "_wb_data"}, wb_data, exp);
    chk({tag, "_wb_rd"}, wb_rd, 7);
    chk({tag, "_wb_rw"}, wb_RegWrite, 1);
  endtask

  initial begin
    rst = 1'b0;
    set_idle();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    step();
    step();
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_rw", wb_RegWrite, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_fwd", forward_ex_mem, 0);
    chk("rst_exm_rd", ex_mem_rd, 0);
    chk("rst_exm_rw", ex_mem_RegWrite, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", stall, 0);
    rst = 1'b1;

    // Stray grant/rvalid with nothing outstanding
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1;
    step();
    chk("stray_req", dmem_req, 0);
    step();
    chk("stray_wb_valid", wb_valid, 0);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;

    // ADD pass-through
    set_ex(1'b1, 32'h0000_1234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    step();
    set_idle();
    #1;
    chk("add_exm_rd", ex_mem_rd, 5);
    chk("add_fwd", forward_ex_mem, 32'h1234);
    chk("add_exm_rw", ex_mem_RegWrite, 1);
    chk("add_stall", stall, 0);
    chk("add_req", dmem_req, 0);
    step();
    chk("add_wb_valid", wb_valid, 1);
    chk("add_wb_rd", wb_rd, 5);
    chk("add_wb_data", wb_data, 32'h1234);
    chk("add_wb_rw", wb_RegWrite, 1);

    // SB with immediate grant
    set_ex(1'b1, 32'h0000_0103, 32'h0000_00AB, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
    step();
    set_idle();
    dmem_gnt = 1'b1;
    #1;
    chk("sb_req", dmem_req, 1);
    chk("sb_we", dmem_we, 1);
    chk("sb_be", dmem_be, 4'b1000);
    chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
    chk("sb_addr", dmem_addr, 32'h100);
    chk("sb_stall", stall, 0);
    step();
    dmem_gnt = 1'b0;
    chk("sb_wb_valid", wb_valid, 1);
    chk("sb_wb_rw", wb_RegWrite, 0);
    chk("sb_req_after", dmem_req, 0);

    // SH with one-cycle grant delay
    set_ex(1'b1, 32'h0000_0102, 32'h1234_CDEF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001);
    step();
    set_idle();
    #1;
    chk("sh_req", dmem_req, 1);
    chk("sh_stall", stall, 1);
    chk("sh_be", dmem_be, 4'b1100);
    chk("sh_wdata", dmem_wdata, 32'hCDEF_CDEF);
    step();
    chk("sh_bubble", wb_valid, 0);
    dmem_gnt = 1'b1;
    #1;
    chk("sh_req_gnt", dmem_req, 1);
    chk("sh_stall_gnt", stall, 0);
    step();
    dmem_gnt = 1'b0;
    chk("sh_wb_valid", wb_valid, 1);
    chk("sh_wb_rw", wb_RegWrite, 0);

    // Loads: alignment and extension
    do_load("lb",  32'h0000_0102, 3'b000, 32'h0080_0000, 0, 1, 32'hFFFF_FF80);
    do_load("lbu", 32'h0000_0102, 3'b100, 32'h0080_0000, 0, 1, 32'h0000_0080);
    do_load("lh",  32'h0000_0102, 3'b001, 32'h8001_0000, 1, 0, 32'hFFFF_8001);
    do_load("lhu", 32'h0000_0102, 3'b101, 32'h8001_0000, 0, 0, 32'h0000_8001);
    do_load("lb0", 32'h0000_0200, 3'b000, 32'h0000_007F, 0, 0, 32'h0000_007F);

    // LW with grant delayed 3 cycles; a different instruction waits upstream
    set_ex(1'b1, 32'h0000_0200, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010);
    step();
    set_ex(1'b1, 32'hDEAD_0000, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 4; i++) begin
      dmem_gnt = (i == 3);
      #1;
      chk("lw_req_held", dmem_req, 1);
      chk("lw_addr_held", dmem_addr, 32'h200);
      chk("lw_stall", stall, 1);
      chk("lw_fwd_held", forward_ex_mem, 32'h200);
      chk("lw_rd_held", ex_mem_rd, 9);
      chk("lw_bubble", wb_valid, 0);
      step();
    end
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    #1;
    chk("lw_stall_done", stall, 0);
    chk("lw_fwd_resp", forward_ex_mem, 32'h200);
    step();
    dmem_rvalid = 1'b0;
    set_idle();
    chk("lw_wb_valid", wb_valid, 1);
    chk("lw_wb_data", wb_data, 32'h1234_5678);
    chk("lw_wb_rd", wb_rd, 9);
    chk("next_fwd", forward_ex_mem, 32'hDEAD_0000);
    step();
    chk("next_wb_data", wb_data, 32'hDEAD_0000);
    chk("next_wb_rd", wb_rd, 3);

    // Reset while in RESP
    set_ex(1'b1, 32'h0000_0300, 32'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010);
    step();
    set_idle();
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    #1;
    chk("rr_stall_resp", stall, 1);
    rst = 1'b0;
    step();
    chk("rr_req", dmem_req, 0);
    chk("rr_stall", stall, 0);
    chk("rr_wb_valid", wb_valid, 0);
    rst = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    step();
    dmem_rvalid = 1'b0;
    chk("rr_late_wb_valid", wb_valid, 0);
    chk("rr_late_stall", stall, 0);
    step();
    chk("rr_late_wb_valid2", wb_valid, 0);

`ifdef MEMORY_STAGE_MISALIGN_CHECK_EN
    set_ex(1'b1, 32'h0000_0102, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010);
    step();
    set_idle();
    #1;
    chk("mis_req", dmem_req, 0);
    chk("mis_stall", stall, 0);
    step();
    chk("mis_err", misalign_err, 1);
    chk("mis_wb_valid", wb_valid, 1);
    chk("mis_wb_rw", wb_RegWrite, 0);
    step();
    chk("mis_err_clear", misalign_err, 0);
`else
    do_load("lw_unal", 32'h0000_0102, 3'b010, 32'hCAFE_BABE, 0, 0, 32'hCAFE_BABE);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline stage between execute and write-back. It registers the execute results (EX/MEM register) and runs a request/grant/response transaction on the data-memory port for loads and stores. It aligns and sign-extends load data and presents a registered MEM/WB result. It also drives the EX/MEM forwarding sources consumed by the execute stage and a stall to the upstream pipeline while a memory access is outstanding.

## Interface
- No parameters; data path fixed at 32 bits.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-low (asserted when 0)
- ex_valid  in  1  execute output holds a valid instruction
- ex_alu_data  in  32  ALU result / effective address
- ex_memory_data  in  32  store data (rs2 value)
- ex_rd  in  5  destination register
- ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg  in  1 each  control bits from execute
- ex_funct3  in  3  access size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010
- stall  out  1  upstream must hold; EX/MEM register does not load
- ex_mem_rd  out  5  rd held in EX/MEM (forwarding)
- ex_mem_RegWrite  out  1  RegWrite held in EX/MEM, gated by valid
- forward_ex_mem  out  32  ALU result held in EX/MEM
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  store data replicated into lanes
- dmem_be  out  4  byte enables
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load word
- wb_valid  out  1  MEM/WB entry valid
- wb_rd  out  5  destination register
- wb_RegWrite  out  1  write enable to register file (already gated by wb_valid)
- wb_data  out  32  ALU result or extended load data

## Operation
- EX/MEM register loads ex_* when stall=0; holds when stall=1.
- FSM states: IDLE, REQ, RESP.
  - IDLE: if EX/MEM valid and (MemRead or MemWrite), assert dmem_req combinationally and go to REQ. If dmem_gnt is already high this cycle, go directly to RESP for a load, or complete a store.
  - REQ: dmem_req held high with stable addr/we/wdata/be until dmem_gnt. On gnt, a store completes; a load goes to RESP.
  - RESP: wait for dmem_rvalid, then capture aligned data and return to IDLE.
- stall = EX/MEM valid and memory op and access not completing this cycle.
- Non-memory instructions pass through to MEM/WB in one cycle with wb_data = ALU result.
- Byte lanes use addr[1:0]:
  - SB: be = 0001<<addr[1:0], wdata = {4{data[7:0]}}.
  - SH: be = 0011<<{addr[1],1'b0}, wdata = {2{data[15:0]}}.
  - SW: be = 1111.
  - Loads select the lane, then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- A store produces wb_valid=1 with wb_RegWrite=0.
- Under stall, MEM/WB writes a bubble (wb_valid=0) each cycle until completion.
- dmem_rvalid outside RESP is ignored. dmem_gnt without dmem_req is ignored.

## Timing
- Reset (rst=0 at clock edge): FSM to IDLE; EX/MEM valid, wb_valid, wb_RegWrite, ex_mem_RegWrite, dmem_req = 0; wb_rd, ex_mem_rd = 0; wb_data, forward_ex_mem = 0.
- Reset mid-transaction aborts it; dmem_req drops in the cycle after the reset edge. No wb output is produced for the aborted access.
- Latency, non-memory: 1 cycle from EX/MEM to wb_*.
- Latency, store with gnt in the first cycle: 1 cycle, no stall.
- Latency, load: wb_valid in the cycle after dmem_rvalid. Minimum is 2 cycles (gnt in cycle 0, rvalid in cycle 1), with stall high for 1 cycle.
- Only one outstanding access at a time.
- Forwarding outputs reflect EX/MEM register contents and stay stable during a stall.

## Configuration
- MEMORY_STAGE_MISALIGN_CHECK_EN defined:
  - A halfword access with addr[0]=1 or a word access with addr[1:0]≠0 issues no dmem_req.
  - It passes to WB in 1 cycle with wb_RegWrite=0.
  - Additional output misalign_err (1 bit, reset 0) pulses for that cycle.
- Undefined:
  - No check and no misalign_err port.
  - Word accesses ignore addr[1:0]; halfword accesses use addr[1] only.

## Test plan
- ADD result 0x0000_1234, rd=5, RegWrite=1 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x1234. ex_mem_rd=5 and forward_ex_mem=0x1234 while the entry is held in EX/MEM.
- SB addr 0x103, data 0xAB, gnt immediate -> dmem_be=1000, dmem_wdata=0xABABABAB, dmem_addr=0x100, no stall, wb_RegWrite=0.
- LB addr 0x102, rdata 0x0080_0000, gnt cycle 0, rvalid cycle 2 -> stall high for 2 cycles, then wb_data=0xFFFFFF80. The same access as LBU -> wb_data=0x00000080.
- LW with gnt delayed 3 cycles -> dmem_req and address held stable 4 cycles, EX/MEM inputs changed during the stall are not captured, wb_valid=0 bubbles.
- rst=0 while in RESP -> next cycle dmem_req=0, stall=0, wb_valid=0. A late dmem_rvalid is ignored.
- With MEMORY_STAGE_MISALIGN_CHECK_EN: LW addr 0x102 -> no dmem_req, misalign_err=1 for one cycle, wb_RegWrite=0.
